// File: rtl/geo_pkg.sv
// geo_pkg: shared types, ASCII constants and record sizing for gga_fix_ctrl (GEO_TX_CKSUM_EN adds a checksum)
package geo_pkg;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_TIME, S_LAT, S_LAT_H, S_LON, S_LON_H, S_EMIT} state_t;
  localparam logic [7:0] C_DOLLAR = 8'h24;
  localparam logic [7:0] C_COMMA  = 8'h2C;
  localparam logic [7:0] C_STAR   = 8'h2A;
  localparam logic [7:0] C_CR     = 8'h0D;
  localparam logic [7:0] C_LF     = 8'h0A;
  localparam logic [7:0] C_N      = 8'h4E;
  localparam logic [7:0] C_S      = 8'h53;
  localparam logic [7:0] C_E      = 8'h45;
  localparam logic [7:0] C_W      = 8'h57;
  localparam logic [7:0] GPGGA [5] = '{8'h47, 8'h50, 8'h47, 8'h47, 8'h41};
`ifdef GEO_TX_CKSUM_EN
  localparam int CK_EXTRA = 3;
`else
  localparam int CK_EXTRA = 0;
`endif
  function automatic logic [4:0] rec_len(input logic [4:0] t, input logic [4:0] l, input logic [4:0] o);
    return t + l + o + 5'd6 + 5'(CK_EXTRA);
  endfunction
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return n < 4'd10 ? {4'h3, n} : 8'h37 + {4'h0, n};
  endfunction
endpackage

// File: rtl/nmea_field_buf.sv
// nmea_field_buf: fixed-depth digit store with clear, count, overflow flag and indexed read
module nmea_field_buf #(
  parameter int LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       wr_i,
  input  logic [3:0] digit_i,
  input  logic [4:0] rd_idx_i,
  output logic [3:0] rd_digit_o,
  output logic [4:0] cnt_o,
  output logic       ovf_o
);
  logic [3:0] mem_q [LEN];
  logic [4:0] cnt_q;
  assign cnt_o = cnt_q;
  assign ovf_o = wr_i && cnt_q == 5'(LEN);
  always_ff @(posedge clk)
    if (!rst || clr_i) begin
      cnt_q <= '0;
      for (int i = 0; i < LEN; i++) mem_q[i] <= '0;
    end else if (wr_i && !ovf_o) begin
      cnt_q <= cnt_q + 5'd1;
      for (int i = 0; i < LEN; i++) if (cnt_q == 5'(i)) mem_q[i] <= digit_i;
    end
  always_comb begin
    rd_digit_o = '0;
    for (int i = 0; i < LEN; i++) if (rd_idx_i == 5'(i)) rd_digit_o = mem_q[i];
  end
endmodule

// File: rtl/gga_fix_ctrl.sv
// gga_fix_ctrl: parses $GPGGA time/lat/lon and streams a compact fix record to the UART transmitter
// GEO_TX_CKSUM_EN appends '*' and a two-digit hex XOR checksum before CR LF.
module gga_fix_ctrl import geo_pkg::*; #(
  parameter int TIME_LEN = 6,
  parameter int LAT_LEN  = 4,
  parameter int LON_LEN  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] uart_data,
  input  logic       uart_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       frame_done,
  output logic       frame_err,
  output logic       rx_overrun,
  output logic       busy
);
  state_t state_q, state_d;
  logic [2:0] hidx_q, hidx_d;
  logic hem_q, hem_d;
  logic [7:0] lat_hem_q, lat_hem_d, lon_hem_q, lon_hem_d;
  logic [4:0] idx_q, idx_d;
  logic done_q, done_d, err_q, err_d, ovr_q, ovr_d;
  logic clr, is_dig, dig_wr, wr_t, wr_l, wr_n, of_t, of_l, of_n, fld_of, xfer, last;
  logic [4:0] cnt_t, cnt_l, cnt_n, fld_cnt, p_lh, p_lc, p_oh, p_cr;
  logic [3:0] dig_t, dig_l, dig_n;
  logic [7:0] hdr_exp, emit_byte;
  assign is_dig  = uart_data >= 8'h30 && uart_data <= 8'h39;
  assign clr     = uart_valid && uart_data == C_DOLLAR && state_q != S_EMIT;
  assign dig_wr  = uart_valid && is_dig;
  assign wr_t    = dig_wr && state_q == S_TIME;
  assign wr_l    = dig_wr && state_q == S_LAT;
  assign wr_n    = dig_wr && state_q == S_LON;
  assign fld_cnt = state_q == S_TIME ? cnt_t : state_q == S_LAT ? cnt_l : cnt_n;
  assign fld_of  = state_q == S_TIME ? of_t : state_q == S_LAT ? of_l : of_n;
  assign hdr_exp = hidx_q == 3'd5 ? C_COMMA : GPGGA[hidx_q];
  assign xfer    = state_q == S_EMIT && tx_ready;
  assign last    = idx_q == rec_len(cnt_t, cnt_l, cnt_n) - 5'd1;
  // Field positions follow from the digit counts actually received, so short fields are not padded
  assign p_lh = cnt_t + cnt_l + 5'd1;
  assign p_lc = p_lh + 5'd1;
  assign p_oh = p_lc + cnt_n + 5'd1;
  assign p_cr = p_oh + 5'd1 + 5'(CK_EXTRA);
  nmea_field_buf #(.LEN(TIME_LEN)) u_time (
    .clk(clk), .rst(rst), .clr_i(clr), .wr_i(wr_t), .digit_i(uart_data[3:0]),
    .rd_idx_i(idx_q), .rd_digit_o(dig_t), .cnt_o(cnt_t), .ovf_o(of_t)
  );
  nmea_field_buf #(.LEN(LAT_LEN)) u_lat (
    .clk(clk), .rst(rst), .clr_i(clr), .wr_i(wr_l), .digit_i(uart_data[3:0]),
    .rd_idx_i(idx_q - cnt_t - 5'd1), .rd_digit_o(dig_l), .cnt_o(cnt_l), .ovf_o(of_l)
  );
  nmea_field_buf #(.LEN(LON_LEN)) u_lon (
    .clk(clk), .rst(rst), .clr_i(clr), .wr_i(wr_n), .digit_i(uart_data[3:0]),
    .rd_idx_i(idx_q - p_lc - 5'd1), .rd_digit_o(dig_n), .cnt_o(cnt_n), .ovf_o(of_n)
  );
`ifdef GEO_TX_CKSUM_EN
  logic [7:0] ck_q;
  always_ff @(posedge clk)
    if (!rst || state_q != S_EMIT) ck_q <= '0;
    else if (xfer && idx_q <= p_oh) ck_q <= ck_q ^ tx_data;
`endif
  assign emit_byte = idx_q < cnt_t ? {4'h3, dig_t}
    : idx_q == cnt_t ? C_COMMA
    : idx_q < p_lh ? {4'h3, dig_l}
    : idx_q == p_lh ? lat_hem_q
    : idx_q == p_lc ? C_COMMA
    : idx_q < p_oh ? {4'h3, dig_n}
    : idx_q == p_oh ? lon_hem_q
`ifdef GEO_TX_CKSUM_EN
    : idx_q == p_oh + 5'd1 ? C_STAR
    : idx_q == p_oh + 5'd2 ? hex_char(ck_q[7:4])
    : idx_q == p_oh + 5'd3 ? hex_char(ck_q[3:0])
`endif
    : idx_q == p_cr ? C_CR : C_LF;
  always_ff @(posedge clk)
    if (!rst) begin
      state_q   <= S_IDLE;
      hidx_q    <= '0;
      hem_q     <= 1'b0;
      lat_hem_q <= '0;
      lon_hem_q <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hidx_q    <= hidx_d;
      hem_q     <= hem_d;
      lat_hem_q <= lat_hem_d;
      lon_hem_q <= lon_hem_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
    end
  always_comb begin
    state_d   = state_q;
    hidx_d    = hidx_q;
    hem_d     = hem_q;
    lat_hem_d = lat_hem_q;
    lon_hem_d = lon_hem_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    ovr_d     = 1'b0;
    err_d     = 1'b0;
    if (state_q == S_EMIT) begin
      ovr_d = uart_valid;
      idx_d = xfer ? idx_q + 5'd1 : idx_q;
      if (xfer && last) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        idx_d   = '0;
      end
    end else if (clr) begin
      state_d = S_HDR;
      hidx_d  = '0;
      hem_d   = 1'b0;
    end else if (uart_valid) begin
      case (state_q)
        S_HDR: begin
          state_d = uart_data != hdr_exp ? S_IDLE : hidx_q == 3'd5 ? S_TIME : S_HDR;
          hidx_d  = hidx_q + 3'd1;
        end
        S_TIME, S_LAT, S_LON: begin
          err_d = is_dig ? fld_of : uart_data != C_COMMA || fld_cnt == 5'd0;
          if (!is_dig && !err_d) state_d = state_q == S_TIME ? S_LAT : state_q == S_LAT ? S_LAT_H : S_LON_H;
        end
        S_LAT_H: begin
          err_d = hem_q ? uart_data != C_COMMA : uart_data != C_N && uart_data != C_S;
          if (!hem_q) lat_hem_d = uart_data;
          hem_d = 1'b1;
          if (hem_q && !err_d) state_d = S_LON;
        end
        S_LON_H: begin
          err_d     = uart_data != C_E && uart_data != C_W;
          lon_hem_d = uart_data;
          if (!err_d) state_d = S_EMIT;
        end
        default: ;
      endcase
      if (err_d) state_d = S_IDLE;
    end
  end
  always_comb begin
    tx_valid   = state_q == S_EMIT;
    tx_data    = tx_valid ? emit_byte : 8'h00;
    busy       = state_q != S_IDLE;
    frame_done = done_q;
    frame_err  = err_q;
    rx_overrun = ovr_q;
  end
endmodule

// File: tb/tb_gga_fix_ctrl.sv
// tb_gga_fix_ctrl: directed sentences against a record-queue model with per-cycle output checking
module tb_gga_fix_ctrl;
`ifdef GEO_TX_CKSUM_EN
  localparam int REC_LEN = 24;
`else
  localparam int REC_LEN = 21;
`endif
  logic clk = 1'b0, rst = 1'b0, uart_valid = 1'b0, tx_ready = 1'b0;
  logic [7:0] uart_data = 8'h00;
  logic [7:0] tx_data;
  logic tx_valid, frame_done, frame_err, rx_overrun, busy;
  int n_pass = 0, n_chk = 0;
  int n_bytes = 0, n_done = 0, n_err = 0, n_ovr = 0, n_vcyc = 0;
  int s_b, s_d, s_e, s_o, s_v;
  int rmode = 0, phase = 0;
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] exp_q [$];
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  gga_fix_ctrl dut (
    .clk(clk), .rst(rst), .uart_data(uart_data), .uart_valid(uart_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .frame_done(frame_done), .frame_err(frame_err), .rx_overrun(rx_overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", nm, act, req);
  endfunction

  // Model: the record is the received fields re-joined in the fixed output layout
  function automatic void expect_rec(input string t, input string la, input string lh, input string lo, input string oh);
    string body;
    body = {t, ",", la, lh, ",", lo, oh};
    for (int i = 0; i < body.len(); i++) exp_q.push_back(body[i]);
`ifdef GEO_TX_CKSUM_EN
    begin
      logic [7:0] x;
      string hx;
      x = 8'h00;
      hx = "0123456789ABCDEF";
      for (int i = 0; i < body.len(); i++) x = x ^ body[i];
      exp_q.push_back(8'h2A);
      exp_q.push_back(hx[x[7:4]]);
      exp_q.push_back(hx[x[3:0]]);
    end
`endif
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  function automatic void snap();
    s_b = n_bytes; s_d = n_done; s_e = n_err; s_o = n_ovr; s_v = n_vcyc;
  endfunction

  function automatic void end_chk(input string t, input int d, input int e, input int o, input int b);
    chk({t, "_done"}, n_done - s_d, d);
    chk({t, "_err"}, n_err - s_e, e);
    chk({t, "_ovr"}, n_ovr - s_o, o);
    chk({t, "_bytes"}, n_bytes - s_b, b);
    chk({t, "_queue_left"}, exp_q.size(), 0);
  endfunction

  always @(posedge clk) begin
    #1;
    tx_ready = rmode == 0 ? 1'b1 : rmode == 2 ? 1'b0 : pat[phase];
    phase = (phase + 1) % 4;
  end

  always @(negedge clk) begin
    if (!rst) prev_stall = 1'b0;
    else begin
      if (tx_valid) n_vcyc++;
      if (prev_stall && tx_valid) chk("stall_hold", int'(tx_data), int'(prev_data));
      if (tx_valid && tx_ready) begin
        n_bytes++;
        if (exp_q.size() == 0) chk("extra_byte", int'(tx_data), -1);
        else chk("rec_byte", int'(tx_data), int'(exp_q.pop_front()));
      end
      if (frame_done) begin
        n_done++;
        chk("done_after_last", exp_q.size(), 0);
        chk("done_valid_low", int'(tx_valid), 0);
      end
      if (frame_err) n_err++;
      if (rx_overrun) n_ovr++;
      prev_stall = tx_valid && !tx_ready;
      prev_data = tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    uart_data = b;
    uart_valid = 1'b1;
    @(posedge clk); #1;
    uart_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (!frame_done && k < 400) begin @(posedge clk); #1; k++; end
    chk(nm, int'(frame_done), 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", int'(tx_valid), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pulses", int'({frame_done, frame_err, rx_overrun}), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    snap();
    expect_rec("123519", "3130", "N", "12024", "E");
    send_byte("$", 1);
    chk("t1_busy_hdr", int'(busy), 1);
    send_str("GPGGA,123519,3130,N,12024,", 1);
    send_byte("E", 0);
    chk("t1_first_valid", int'(tx_valid), 1);
    chk("t1_first_byte", int'(tx_data), 8'h31);
    wait_done("t1_done_seen");
    chk("t1_idle_after", int'(busy), 0);
    send_byte("$", 1);
    end_chk("t1", 1, 0, 0, REC_LEN);
    rmode = 1;
    snap();
    expect_rec("123519", "3130", "N", "12024", "E");
    send_str("GPGGA,123519,3130,N,12024,E", 1);
    wait_done("t2_done_seen");
    repeat (2) begin @(posedge clk); #1; end
    end_chk("t2", 1, 0, 0, REC_LEN);
    rmode = 0;
    snap();
    send_str("$GPRMC,123519,3130,N,12024,E", 1);
    repeat (2) begin @(posedge clk); #1; end
    end_chk("t3_rmc", 0, 0, 0, 0);
    chk("t3_rmc_no_valid", n_vcyc - s_v, 0);
    snap();
    send_str("$GPGGA,123519,31A0,N,12024,E", 1);
    repeat (2) begin @(posedge clk); #1; end
    end_chk("t3_badlat", 0, 1, 0, 0);
    chk("t3_badlat_no_valid", n_vcyc - s_v, 0);
    snap();
    send_str("$GPGGA,123519,3130", 1);
    send_byte("0", 0);
    chk("t4_err_on_fifth", int'(frame_err), 1);
    send_str(",N,12024,E", 1);
    repeat (2) begin @(posedge clk); #1; end
    end_chk("t4", 0, 1, 0, 0);
    chk("t4_no_valid", n_vcyc - s_v, 0);
    snap();
    expect_rec("123519", "3130", "N", "12024", "E");
    send_str("$GPGGA,12$GPGGA,123519,3130,N,12024,E", 1);
    wait_done("t5_done_seen");
    repeat (2) begin @(posedge clk); #1; end
    end_chk("t5_restart", 1, 0, 0, REC_LEN);
    rmode = 2;
    repeat (2) begin @(posedge clk); #1; end
    snap();
    expect_rec("123519", "3130", "N", "12024", "E");
    send_str("$GPGGA,123519,3130,N,12024,E", 1);
    chk("t5_stalled_valid", int'(tx_valid), 1);
    send_str("xyz", 1);
    rmode = 0;
    wait_done("t5_ovr_done_seen");
    repeat (2) begin @(posedge clk); #1; end
    end_chk("t5_overrun", 1, 0, 3, REC_LEN);
    snap();
    expect_rec("123519", "3130", "N", "12024", "E");
    send_str("$GPGGA,123519,3130,N,12024,", 1);
    send_byte("E", 0);
    begin
      int k;
      k = 0;
      while (n_bytes - s_b < 5 && k < 50) begin @(posedge clk); #1; k++; end
    end
    chk("t6_five_bytes", n_bytes - s_b, 5);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_valid", int'(tx_valid), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_data", int'(tx_data), 0);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) begin @(posedge clk); #1; end
    chk("t6_no_resume", int'(tx_valid), 0);
    snap();
    expect_rec("123519", "3130", "N", "12024", "E");
    send_str("$GPGGA,123519,3130,N,12024,E", 1);
    wait_done("t6_done_seen");
    repeat (2) begin @(posedge clk); #1; end
    end_chk("t6", 1, 0, 0, REC_LEN);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "timeout");
  end
endmodule
